// File: rtl/fifo_check_drain_if.sv
// fifo_check_drain_if
//   Bundles the FIFO read port, the run configuration, the result registers and
//   the ap_* control handshake of fifo_check_drain.
//   slave  : the checker side (fifo_check_drain)
//   master : the sequencer / FIFO side (drives size, times, ap_start, FIFO data/flags)
interface fifo_check_drain_if #(
  parameter int WIDTH = 8
);
  logic [31:0]      size;
  logic [31:0]      times;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_rd_data;
  logic             fifo_empty;
  logic [31:0]      err_count;
  logic [31:0]      first_err_idx;
  logic [WIDTH-1:0] first_err_data;
  logic             ap_start;
  logic             ap_idle;
  logic             ap_ready;
  logic             ap_done;

  modport slave (
    input  size, times, fifo_rd_data, fifo_empty, ap_start,
    output fifo_rd_en, err_count, first_err_idx, first_err_data,
           ap_idle, ap_ready, ap_done
  );

  modport master (
    output size, times, fifo_rd_data, fifo_empty, ap_start,
    input  fifo_rd_en, err_count, first_err_idx, first_err_data,
           ap_idle, ap_ready, ap_done
  );
endinterface

// File: rtl/fifo_check_drain.sv
// fifo_check_drain
//   Drains size*times words from the generator FIFO and checks each word against
//   the generator pattern (word index within the pass, modulo 2^WIDTH). Reports a
//   saturating error count plus index/data of the first mismatch.
// Ports
//   ap_clk : clock, all logic on posedge
//   ap_rst : asynchronous active-high reset (aborts a run, no ap_done)
//   bus    : fifo_check_drain_if.slave -- FIFO read port, size/times, results,
//            ap_start/ap_idle/ap_ready/ap_done handshake
// WIDTH must match the WIDTH of the connected interface instance.
//
// state | meaning
// IDLE  | waiting for ap_start; results of the last run held
// RUN   | issuing reads and comparing returned words
// DONE  | one-cycle ap_done pulse, then back to IDLE
module fifo_check_drain #(
  parameter int WIDTH        = 8,
  parameter int STALL_PERIOD = 0
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  fifo_check_drain_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [31:0]      size_q, times_q;
  logic [31:0]      iss_word_q, iss_pass_q;   // read-issue position
  logic [31:0]      word_idx_q, pass_idx_q;   // compare position
  logic [31:0]      global_idx_q;
  logic [31:0]      err_count_q, first_err_idx_q;
  logic [WIDTH-1:0] first_err_data_q;
  logic             rd_vld_q;

  logic rd_en, start_acc, stall, idle, ready, done;
  logic last_cmp, mismatch;

  assign last_cmp = (word_idx_q == size_q - 32'd1) && (pass_idx_q == times_q - 32'd1);
  assign mismatch = bus.fifo_rd_data != word_idx_q[WIDTH-1:0];

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // rd_en is purely combinational from state_q, so it falls as soon as the
  // asynchronous reset forces state_q back to IDLE.
  always_comb begin
    state_d   = state_q;
    idle      = 1'b0;
    ready     = 1'b0;
    done      = 1'b0;
    rd_en     = 1'b0;
    start_acc = 1'b0;
    case (state_q)
      S_IDLE: begin
        idle = 1'b1;
        if (bus.ap_start) begin
          ready     = 1'b1;
          start_acc = 1'b1;
          state_d   = (bus.size == 32'd0 || bus.times == 32'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        rd_en = !bus.fifo_empty && (iss_pass_q < times_q) && !stall;
        if (rd_vld_q && last_cmp) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  generate
    if (STALL_PERIOD > 0) begin : g_stall
      logic [31:0] stall_cnt_q;
      assign stall = (stall_cnt_q == 32'(STALL_PERIOD - 1));
      always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst)                stall_cnt_q <= '0;
        else if (start_acc)        stall_cnt_q <= '0;
        else if (state_q == S_RUN) stall_cnt_q <= stall ? 32'd0 : stall_cnt_q + 32'd1;
      end
    end else begin : g_no_stall
      assign stall = 1'b0;
    end
  endgenerate

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      size_q           <= '0;
      times_q          <= '0;
      iss_word_q       <= '0;
      iss_pass_q       <= '0;
      word_idx_q       <= '0;
      pass_idx_q       <= '0;
      global_idx_q     <= '0;
      err_count_q      <= '0;
      first_err_idx_q  <= '0;
      first_err_data_q <= '0;
      rd_vld_q         <= 1'b0;
    end else begin
      rd_vld_q <= rd_en;
      if (start_acc) begin
        size_q           <= bus.size;
        times_q          <= bus.times;
        iss_word_q       <= '0;
        iss_pass_q       <= '0;
        word_idx_q       <= '0;
        pass_idx_q       <= '0;
        global_idx_q     <= '0;
        err_count_q      <= '0;
        first_err_idx_q  <= '0;
        first_err_data_q <= '0;
      end else begin
        if (rd_en) begin
          if (iss_word_q == size_q - 32'd1) begin
            iss_word_q <= '0;
            iss_pass_q <= iss_pass_q + 32'd1;
          end else begin
            iss_word_q <= iss_word_q + 32'd1;
          end
        end
        if (rd_vld_q) begin
          global_idx_q <= global_idx_q + 32'd1;
          if (word_idx_q == size_q - 32'd1) begin
            word_idx_q <= '0;
            pass_idx_q <= pass_idx_q + 32'd1;
          end else begin
            word_idx_q <= word_idx_q + 32'd1;
          end
          if (mismatch) begin
            // count never returns to zero once set, so zero marks "no error yet"
            if (err_count_q == 32'd0) begin
              first_err_idx_q  <= global_idx_q;
              first_err_data_q <= bus.fifo_rd_data;
            end
            if (err_count_q != 32'hFFFF_FFFF) err_count_q <= err_count_q + 32'd1;
          end
        end
      end
    end
  end

  assign bus.fifo_rd_en     = rd_en;
  assign bus.ap_idle        = idle;
  assign bus.ap_ready       = ready;
  assign bus.ap_done        = done;
  assign bus.err_count      = err_count_q;
  assign bus.first_err_idx  = first_err_idx_q;
  assign bus.first_err_data = first_err_data_q;

endmodule

// File: tb/tb_fifo_check_drain.sv
module tb_fifo_check_drain;
  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  always #5 ap_clk = ~ap_clk;

  fifo_check_drain_if #(.WIDTH(8)) if0 ();
  fifo_check_drain_if #(.WIDTH(8)) if1 ();

  fifo_check_drain #(.WIDTH(8), .STALL_PERIOD(0)) dut0 (.ap_clk(ap_clk), .ap_rst(ap_rst), .bus(if0.slave));
  fifo_check_drain #(.WIDTH(8), .STALL_PERIOD(3)) dut1 (.ap_clk(ap_clk), .ap_rst(ap_rst), .bus(if1.slave));

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int rdcnt0 = 0, rdcnt1 = 0, donecnt0 = 0, donecnt1 = 0;
  int underrun = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // FIFO models: data appears the cycle after rd_en
  always @(posedge ap_clk) begin
    if (if0.fifo_rd_en) begin
      rdcnt0 <= rdcnt0 + 1;
      if (q0.size() > 0) if0.fifo_rd_data <= q0.pop_front();
      else underrun <= underrun + 1;
    end
    if (if1.fifo_rd_en) begin
      rdcnt1 <= rdcnt1 + 1;
      if (q1.size() > 0) if1.fifo_rd_data <= q1.pop_front();
      else underrun <= underrun + 1;
    end
    if (if0.ap_done) donecnt0 <= donecnt0 + 1;
    if (if1.ap_done) donecnt1 <= donecnt1 + 1;
  end

  always @(negedge ap_clk) begin
    if0.fifo_empty <= (q0.size() == 0);
    if1.fifo_empty <= (q1.size() == 0);
  end

  // One run on dut0 with a full FIFO; expectations come from the pattern rule.
  task automatic run0(input string tag, input int sz, input int tm, input int pct,
                      input int cidx, input logic [7:0] cval, input int extra);
    int total, exp_err, exp_fidx, rd_start, done_start, lat, exp_lat;
    logic [7:0] v, good, exp_fd;
    total = sz * tm; exp_err = 0; exp_fidx = 0; exp_fd = 8'h00;
    q0.delete();
    for (int g = 0; g < total; g++) begin
      good = 8'(g % sz);
      v = good;
      if (g == cidx) v = cval;
      else if ($urandom_range(99) < pct) v = good ^ 8'($urandom_range(255, 1));
      if (v != good) begin
        if (exp_err == 0) begin exp_fidx = g; exp_fd = v; end
        exp_err++;
      end
      q0.push_back(v);
    end
    for (int k = 0; k < extra; k++) q0.push_back(8'($urandom));
    repeat (2) @(negedge ap_clk);
    rd_start = rdcnt0; done_start = donecnt0;
    if0.size = 32'(sz); if0.times = 32'(tm); if0.ap_start = 1'b1;
    #1;
    check_eq({tag, ".ready"}, 64'(if0.ap_ready), 64'd1);
    @(negedge ap_clk);
    if0.ap_start = 1'b0;
    lat = 1;
    while (!if0.ap_done && lat < total + 50) begin
      @(negedge ap_clk);
      lat++;
    end
    exp_lat = (total == 0) ? 1 : total + 2;
    check_eq({tag, ".done"}, 64'(if0.ap_done), 64'd1);
    check_eq({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, ".err_count"}, 64'(if0.err_count), 64'(exp_err));
    check_eq({tag, ".first_idx"}, 64'(if0.first_err_idx), 64'(exp_fidx));
    check_eq({tag, ".first_data"}, 64'(if0.first_err_data), 64'(exp_fd));
    check_eq({tag, ".reads"}, 64'(rdcnt0 - rd_start), 64'(total));
    check_eq({tag, ".leftover"}, 64'(q0.size()), 64'(extra));
    @(negedge ap_clk);
    check_eq({tag, ".done_once"}, 64'(donecnt0 - done_start), 64'd1);
    check_eq({tag, ".idle_after"}, 64'(if0.ap_idle), 64'd1);
  endtask

  initial begin
    int n, rd_hits, sz, tm, rd_start, bound;
    if0.ap_start = 0; if0.size = 0; if0.times = 0; if0.fifo_rd_data = 0;
    if1.ap_start = 0; if1.size = 0; if1.times = 0; if1.fifo_rd_data = 0;
    repeat (3) @(negedge ap_clk);
    check_eq("rst.idle", 64'(if0.ap_idle), 64'd1);
    check_eq("rst.rd_en", 64'(if0.fifo_rd_en), 64'd0);
    check_eq("rst.ready", 64'(if0.ap_ready), 64'd0);
    check_eq("rst.done", 64'(if0.ap_done), 64'd0);
    check_eq("rst.err", 64'(if0.err_count), 64'd0);
    check_eq("rst.fidx", 64'(if0.first_err_idx), 64'd0);
    check_eq("rst.fdata", 64'(if0.first_err_data), 64'd0);
    ap_rst = 1'b0;

    run0("t1", 16, 2, 0, -1, 8'h00, 3);
    run0("t2", 300, 1, 0, -1, 8'h00, 0);
    run0("t3", 8, 1, 0, 5, 8'hAA, 0);
    run0("t4", 0, 7, 0, -1, 8'h00, 2);
    run0("t4b", 5, 0, 0, -1, 8'h00, 1);
    for (int r = 0; r < 6; r++) begin
      sz = int'($urandom_range(40, 1));
      tm = int'($urandom_range(3, 1));
      run0($sformatf("rnd%0d", r), sz, tm, 15, -1, 8'h00, int'($urandom_range(5)));
    end

    // FIFO empty in RUN: block waits, no reads, no done
    q0.delete();
    repeat (2) @(negedge ap_clk);
    rd_start = rdcnt0;
    if0.size = 4; if0.times = 1; if0.ap_start = 1'b1;
    @(negedge ap_clk);
    if0.ap_start = 1'b0;
    rd_hits = 0;
    for (int c = 0; c < 20; c++) begin
      if (if0.fifo_rd_en || if0.ap_done) rd_hits++;
      @(negedge ap_clk);
    end
    check_eq("empty.no_read", 64'(rd_hits), 64'd0);
    check_eq("empty.busy", 64'(if0.ap_idle), 64'd0);
    for (int k = 0; k < 4; k++) q0.push_back(8'(k));
    n = 0;
    while (!if0.ap_done && n < 50) begin @(negedge ap_clk); n++; end
    check_eq("empty.done", 64'(if0.ap_done), 64'd1);
    check_eq("empty.err", 64'(if0.err_count), 64'd0);
    check_eq("empty.reads", 64'(rdcnt0 - rd_start), 64'd4);

    // Reset after 4 of 16 reads
    q0.delete();
    for (int k = 0; k < 16; k++) q0.push_back(8'(k) ^ 8'h5A);
    repeat (2) @(negedge ap_clk);
    rd_start = rdcnt0;
    n = donecnt0;
    if0.size = 16; if0.times = 1; if0.ap_start = 1'b1;
    @(negedge ap_clk);
    if0.ap_start = 1'b0;
    bound = 0;
    while (rdcnt0 - rd_start < 4 && bound < 50) begin @(negedge ap_clk); bound++; end
    check_eq("t6.reads_before", 64'(rdcnt0 - rd_start), 64'd4);
    ap_rst = 1'b1;
    #1;
    check_eq("t6.rd_en_drop", 64'(if0.fifo_rd_en), 64'd0);
    check_eq("t6.idle_now", 64'(if0.ap_idle), 64'd1);
    check_eq("t6.err_clr", 64'(if0.err_count), 64'd0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    repeat (3) @(negedge ap_clk);
    check_eq("t6.leftover", 64'(q0.size()), 64'd12);
    check_eq("t6.no_done", 64'(donecnt0 - n), 64'd0);
    run0("t6r", 16, 1, 0, -1, 8'h00, 0);

    // Stall pattern on dut1: 110 repeating
    q1.delete();
    for (int k = 0; k < 20; k++) q1.push_back(8'(k));
    repeat (2) @(negedge ap_clk);
    rd_start = rdcnt1;
    n = donecnt1;
    if1.size = 9; if1.times = 1; if1.ap_start = 1'b1;
    @(negedge ap_clk);
    if1.ap_start = 1'b0;
    for (int j = 1; j <= 13; j++) begin
      check_eq($sformatf("t5.rd%0d", j), 64'(if1.fifo_rd_en), 64'(((j - 1) % 3) != 2));
      @(negedge ap_clk);
    end
    bound = 0;
    while (!if1.ap_done && bound < 20) begin @(negedge ap_clk); bound++; end
    check_eq("t5.done", 64'(if1.ap_done), 64'd1);
    check_eq("t5.err", 64'(if1.err_count), 64'd0);
    check_eq("t5.reads", 64'(rdcnt1 - rd_start), 64'd9);
    check_eq("t5.leftover", 64'(q1.size()), 64'd11);
    @(negedge ap_clk);
    check_eq("t5.done_once", 64'(donecnt1 - n), 64'd1);

    check_eq("underrun", 64'(underrun), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
